// File: rtl/shifter_video_sequencer.sv
// Video timing and shifter fetch/load sequencer: divides the 32 MHz clock into
// ST cycles and generates display enable, load strobes, fetches and syncs.
module shifter_video_sequencer #(
    parameter int unsigned H_TOTAL    = 512,
    parameter int unsigned H_DE_START = 56,
    parameter int unsigned H_DE_END   = 376,
    parameter int unsigned V_TOTAL    = 313,
    parameter int unsigned V_DE_START = 63,
    parameter int unsigned V_DE_END   = 263,
    parameter int unsigned HSYNC_LEN  = 40,
    parameter int unsigned VSYNC_LEN  = 3,
    parameter int unsigned LOAD_DELAY = 6,
    parameter int unsigned AW         = 22
) (
    input  logic          CLOCK_32,
    input  logic          reset,
    input  logic          enable,
    input  logic [AW-1:0] vbase,
    output logic          de,
    output logic          load,
    output logic          mem_rd,
    output logic [AW-1:0] vid_addr,
    output logic          hsync_n,
    output logic          vsync_n
);

    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    // Load slots span the same number of ST cycles as de, shifted by the wakestate delay.
    localparam int unsigned LOAD_FIRST  = H_DE_START + LOAD_DELAY;
    localparam int unsigned LOAD_END    = H_DE_END + LOAD_DELAY;
    localparam int unsigned FETCH_FIRST = LOAD_FIRST - 1;
    localparam int unsigned FETCH_END   = LOAD_END - 1;

    logic [1:0]    ph_q, ph_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          line_en_q, line_en_d;
    logic          de_q, de_d;
    logic          load_q, load_d;
    logic          mem_rd_q, mem_rd_d;
    logic [AW-1:0] vid_addr_q, vid_addr_d;
    logic          hsync_n_q, hsync_n_d;
    logic          vsync_n_q, vsync_n_d;

    logic          st_edge;
    logic [31:0]   hx;
    logic [31:0]   vx;
    logic          v_act;
    logic          slot;
    logic          fetch;

    // Next-state and next-output decode; everything moves only on the ST boundary.
    always_comb begin
        ph_d       = ph_q + 2'd1;
        h_d        = h_q;
        v_d        = v_q;
        line_en_d  = line_en_q;
        de_d       = de_q;
        load_d     = load_q;
        mem_rd_d   = mem_rd_q;
        vid_addr_d = vid_addr_q;
        hsync_n_d  = hsync_n_q;
        vsync_n_d  = vsync_n_q;
        st_edge    = (ph_q == 2'd3);
        hx         = 32'd0;
        vx         = 32'd0;
        v_act      = 1'b0;
        slot       = 1'b0;
        fetch      = 1'b0;

        if (st_edge) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end
            hx = 32'(h_d);
            vx = 32'(v_d);

            // A line's slots are enabled only if enable was high at its start and stays high.
            line_en_d = (h_d == '0) ? enable : (line_en_q && enable);

            v_act = (vx >= V_DE_START) && (vx < V_DE_END);
            de_d  = enable && v_act && (hx >= H_DE_START) && (hx < H_DE_END);

            slot  = line_en_d && v_act && (hx >= LOAD_FIRST) && (hx < LOAD_END)
                    && (((hx - LOAD_FIRST) & 32'd3) == 32'd0);
            fetch = line_en_d && v_act && (hx >= FETCH_FIRST) && (hx < FETCH_END)
                    && (((hx - FETCH_FIRST) & 32'd3) == 32'd0);

            load_d    = !slot;
            mem_rd_d  = fetch;
            hsync_n_d = !(hx < HSYNC_LEN);
            vsync_n_d = !(vx < VSYNC_LEN);

            // Frame start reloads the base; otherwise advance when a load slot ends.
            if ((h_d == '0) && (v_d == '0)) begin
                vid_addr_d = vbase;
            end else if (!load_q) begin
                vid_addr_d = vid_addr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_32) begin
        if (reset) begin
            ph_q       <= 2'd0;
            h_q        <= '0;
            v_q        <= '0;
            line_en_q  <= 1'b1;
            de_q       <= 1'b0;
            load_q     <= 1'b1;
            mem_rd_q   <= 1'b0;
            vid_addr_q <= vbase;
            hsync_n_q  <= (HSYNC_LEN == 0);
            vsync_n_q  <= (VSYNC_LEN == 0);
        end else begin
            ph_q       <= ph_d;
            h_q        <= h_d;
            v_q        <= v_d;
            line_en_q  <= line_en_d;
            de_q       <= de_d;
            load_q     <= load_d;
            mem_rd_q   <= mem_rd_d;
            vid_addr_q <= vid_addr_d;
            hsync_n_q  <= hsync_n_d;
            vsync_n_q  <= vsync_n_d;
        end
    end

    assign de       = de_q;
    assign load     = load_q;
    assign mem_rd   = mem_rd_q;
    assign vid_addr = vid_addr_q;
    assign hsync_n  = hsync_n_q;
    assign vsync_n  = vsync_n_q;

endmodule

// File: tb/tb_shifter_video_sequencer.sv
// Directed bench: a small-geometry instance for line/frame timing and a
// default-horizontal instance (short frame) for full-line strobe counts.
module tb_shifter_video_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [21:0] vbase;

    logic        s_de, s_load, s_mem_rd, s_hsync_n, s_vsync_n;
    logic [21:0] s_vid_addr;
    logic        d_de, d_load, d_mem_rd, d_hsync_n, d_vsync_n;
    logic [21:0] d_vid_addr;

    int t;
    int n_pass;
    int n_total;

    always #5 clk = ~clk;

    shifter_video_sequencer #(
        .H_TOTAL(64), .H_DE_START(8), .H_DE_END(24), .V_TOTAL(8), .V_DE_START(2),
        .V_DE_END(4), .HSYNC_LEN(4), .VSYNC_LEN(1), .LOAD_DELAY(6), .AW(22)
    ) dut_s (
        .CLOCK_32(clk), .reset(reset), .enable(enable), .vbase(vbase),
        .de(s_de), .load(s_load), .mem_rd(s_mem_rd), .vid_addr(s_vid_addr),
        .hsync_n(s_hsync_n), .vsync_n(s_vsync_n)
    );

    // Default horizontal timing with a short 8-line frame to keep run time small.
    shifter_video_sequencer #(
        .V_TOTAL(8), .V_DE_START(2), .V_DE_END(4), .VSYNC_LEN(3)
    ) dut_d (
        .CLOCK_32(clk), .reset(reset), .enable(enable), .vbase(vbase),
        .de(d_de), .load(d_load), .mem_rd(d_mem_rd), .vid_addr(d_vid_addr),
        .hsync_n(d_hsync_n), .vsync_n(d_vsync_n)
    );

    task automatic tick();
        @(posedge clk);
        t = t + 1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        t = 0;
    endtask

    task automatic goto(input int target);
        while (t < target) tick();
    endtask

    // Checks one full active small-config line starting at its first clock.
    task automatic check_line(input logic [21:0] a0, input string tag);
        logic de_e, ld_e, mr_e, hs_e;
        logic [21:0] ad_e;
        for (int c = 0; c < 256; c++) begin
            de_e = (c >= 32 && c < 96);
            ld_e = !(c >= 56 && c < 120 && ((c - 56) % 16) < 4);
            mr_e = (c >= 52 && c < 116 && ((c - 52) % 16) < 4);
            hs_e = (c >= 16);
            n_total++;
            if (s_de !== de_e) $display("FAIL %s de c=%0d got %b want %b", tag, c, s_de, de_e);
            else n_pass++;
            n_total++;
            if (s_load !== ld_e) $display("FAIL %s load c=%0d got %b want %b", tag, c, s_load, ld_e);
            else n_pass++;
            n_total++;
            if (s_mem_rd !== mr_e) $display("FAIL %s mem_rd c=%0d got %b want %b", tag, c, s_mem_rd, mr_e);
            else n_pass++;
            n_total++;
            if (s_hsync_n !== hs_e) $display("FAIL %s hsync_n c=%0d got %b want %b", tag, c, s_hsync_n, hs_e);
            else n_pass++;
            n_total++;
            if (s_vsync_n !== 1'b1) $display("FAIL %s vsync_n c=%0d got %b want 1", tag, c, s_vsync_n);
            else n_pass++;
            if (mr_e) begin
                ad_e = a0 + 22'((c - 52) / 16);
                n_total++;
                if (s_vid_addr !== ad_e) $display("FAIL %s vid_addr c=%0d got %h want %h", tag, c, s_vid_addr, ad_e);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        vbase = 22'h000100;
        enable = 1'b1;
        do_reset();
        n_total++;
        if (s_de !== 1'b0) $display("FAIL rst de got %b want 0", s_de); else n_pass++;
        n_total++;
        if (s_load !== 1'b1) $display("FAIL rst load got %b want 1", s_load); else n_pass++;
        n_total++;
        if (s_mem_rd !== 1'b0) $display("FAIL rst mem_rd got %b want 0", s_mem_rd); else n_pass++;
        n_total++;
        if (s_hsync_n !== 1'b0) $display("FAIL rst hsync_n got %b want 0", s_hsync_n); else n_pass++;
        n_total++;
        if (s_vsync_n !== 1'b0) $display("FAIL rst vsync_n got %b want 0", s_vsync_n); else n_pass++;
        n_total++;
        if (s_vid_addr !== 22'h000100) $display("FAIL rst vid_addr got %h want 000100", s_vid_addr); else n_pass++;
        goto(15);
        n_total++;
        if (s_hsync_n !== 1'b0) $display("FAIL hsync_end got %b want 0", s_hsync_n); else n_pass++;
        tick();
        n_total++;
        if (s_hsync_n !== 1'b1) $display("FAIL hsync_rise got %b want 1", s_hsync_n); else n_pass++;
        goto(255);
        n_total++;
        if (s_vsync_n !== 1'b0) $display("FAIL vsync_end got %b want 0", s_vsync_n); else n_pass++;
        tick();
        n_total++;
        if (s_vsync_n !== 1'b1) $display("FAIL vsync_rise got %b want 1", s_vsync_n); else n_pass++;
    endtask

    task automatic test_line_timing();
        goto(512);
        check_line(22'h000100, "f0_line2");
        check_line(22'h000104, "f0_line3");
    endtask

    task automatic test_frame_wrap_vbase();
        goto(2048 + 512);
        check_line(22'h000100, "f1_line2");
        goto(2048 + 768);
        vbase = 22'h000200;
        check_line(22'h000104, "f1_line3");
        goto(4095);
        n_total++;
        if (s_vid_addr !== 22'h000108) $display("FAIL pre_wrap vid_addr got %h want 000108", s_vid_addr); else n_pass++;
        tick();
        n_total++;
        if (s_vid_addr !== 22'h000200) $display("FAIL reload vid_addr got %h want 000200", s_vid_addr); else n_pass++;
        goto(4096 + 512);
        check_line(22'h000200, "f2_line2");
    endtask

    task automatic test_enable_drop();
        logic de_e, ld_e, mr_e;
        logic [21:0] ad_e;
        vbase = 22'h000100;
        enable = 1'b1;
        do_reset();
        goto(512);
        for (int c = 0; c < 256; c++) begin
            de_e = (c >= 32 && c < 76);
            ld_e = !(c >= 56 && c < 76 && ((c - 56) % 16) < 4);
            mr_e = (c >= 52 && c < 76 && ((c - 52) % 16) < 4);
            n_total++;
            if (s_de !== de_e) $display("FAIL en_drop de c=%0d got %b want %b", c, s_de, de_e);
            else n_pass++;
            n_total++;
            if (s_load !== ld_e) $display("FAIL en_drop load c=%0d got %b want %b", c, s_load, ld_e);
            else n_pass++;
            n_total++;
            if (s_mem_rd !== mr_e) $display("FAIL en_drop mem_rd c=%0d got %b want %b", c, s_mem_rd, mr_e);
            else n_pass++;
            if (mr_e) begin
                ad_e = 22'h000100 + 22'((c - 52) / 16);
                n_total++;
                if (s_vid_addr !== ad_e) $display("FAIL en_drop vid_addr c=%0d got %h want %h", c, s_vid_addr, ad_e);
                else n_pass++;
            end
            if (c == 73) enable = 1'b0;
            if (c == 100) enable = 1'b1;
            tick();
        end
        check_line(22'h000102, "en_line3");
    endtask

    task automatic test_reset_mid_slot();
        vbase = 22'h000100;
        enable = 1'b1;
        do_reset();
        goto(512 + 57);
        n_total++;
        if (s_load !== 1'b0) $display("FAIL mid_slot load got %b want 0", s_load); else n_pass++;
        vbase = 22'h000180;
        do_reset();
        n_total++;
        if (s_load !== 1'b1) $display("FAIL rst2 load got %b want 1", s_load); else n_pass++;
        n_total++;
        if (s_de !== 1'b0) $display("FAIL rst2 de got %b want 0", s_de); else n_pass++;
        n_total++;
        if (s_mem_rd !== 1'b0) $display("FAIL rst2 mem_rd got %b want 0", s_mem_rd); else n_pass++;
        n_total++;
        if (s_hsync_n !== 1'b0) $display("FAIL rst2 hsync_n got %b want 0", s_hsync_n); else n_pass++;
        n_total++;
        if (s_vsync_n !== 1'b0) $display("FAIL rst2 vsync_n got %b want 0", s_vsync_n); else n_pass++;
        n_total++;
        if (s_vid_addr !== 22'h000180) $display("FAIL rst2 vid_addr got %h want 000180", s_vid_addr); else n_pass++;
        goto(512);
        check_line(22'h000180, "rst2_line2");
    endtask

    task automatic test_default();
        int n_ld, n_str, n_mr, n_de, n_hs;
        logic prev_ld;
        logic vs_e;
        n_ld = 0; n_str = 0; n_mr = 0; n_de = 0; n_hs = 0;
        prev_ld = 1'b1;
        vbase = 22'h3FFFC0;
        enable = 1'b1;
        do_reset();
        while (t <= 16384) begin
            if (t >= 4096 && t < 6144) begin
                if (!d_load) n_ld++;
                if (prev_ld && !d_load) n_str++;
                if (d_mem_rd) n_mr++;
                if (d_de) n_de++;
            end
            prev_ld = d_load;
            if (t < 2048 && !d_hsync_n) n_hs++;
            if ((t % 2048) == 1000 && t < 5 * 2048) begin
                vs_e = ((t / 2048) >= 3);
                n_total++;
                if (d_vsync_n !== vs_e) $display("FAIL dflt vsync_n line=%0d got %b want %b", t / 2048, d_vsync_n, vs_e);
                else n_pass++;
            end
            if (t == 6144) begin
                n_total++;
                if (d_vid_addr !== 22'h000010) $display("FAIL dflt line3 vid_addr got %h want 000010", d_vid_addr);
                else n_pass++;
            end
            if (t == 16383) begin
                n_total++;
                if (d_vid_addr !== 22'h000060) $display("FAIL dflt frame_end vid_addr got %h want 000060", d_vid_addr);
                else n_pass++;
            end
            if (t == 16384) begin
                n_total++;
                if (d_vid_addr !== 22'h3FFFC0) $display("FAIL dflt reload vid_addr got %h want 3fffc0", d_vid_addr);
                else n_pass++;
                break;
            end
            tick();
        end
        n_total++;
        if (n_str !== 80) $display("FAIL dflt strobes got %0d want 80", n_str); else n_pass++;
        n_total++;
        if (n_ld !== 320) $display("FAIL dflt load_low_clocks got %0d want 320", n_ld); else n_pass++;
        n_total++;
        if (n_mr !== 320) $display("FAIL dflt mem_rd_clocks got %0d want 320", n_mr); else n_pass++;
        n_total++;
        if (n_de !== 1280) $display("FAIL dflt de_clocks got %0d want 1280", n_de); else n_pass++;
        n_total++;
        if (n_hs !== 160) $display("FAIL dflt hsync_low_clocks got %0d want 160", n_hs); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        t = 0;
        reset = 1'b1;
        enable = 1'b1;
        vbase = 22'h000100;
        test_reset();
        test_line_timing();
        test_frame_wrap_vbase();
        test_enable_drop();
        test_reset_mid_slot();
        test_default();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/shifter_video_sequencer.md
Name: shifter_video_sequencer

Overview:
- Generates the video timing and fetch/load sequence that drives the shifter: display enable `de`, active-low `load` strobes, sync pulses and the video RAM word address.
- Runs on the 32 MHz shifter clock and divides it by 4 internally into ST cycles (8 MHz).
- Sits between the memory controller, which services `mem_rd`/`vid_addr`, and the shifter, which consumes `de`/`load` together with the data bus.

Parameters:
- H_TOTAL, 512: ST cycles per scanline.
- H_DE_START, 56: h count at which `de` rises.
- H_DE_END, 376: h count at which `de` falls (exclusive). (H_DE_END - H_DE_START) must be a multiple of 4.
- V_TOTAL, 313: scanlines per frame.
- V_DE_START, 63: first active line.
- V_DE_END, 263: first inactive line after the active region.
- HSYNC_LEN, 40: ST cycles of `hsync_n` low, starting at h=0.
- VSYNC_LEN, 3: lines of `vsync_n` low, starting at v=0.
- LOAD_DELAY, 6: ST cycles from `de` rise to the first load slot (wakestate offset, legal range 3..6).
- AW, 22: width of the video word address.
- Constraint: H_DE_END + LOAD_DELAY < H_TOTAL.

Ports:
- CLOCK_32, input, 1: 32 MHz clock. All logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: video on. When 0, `de`, `load`, `mem_rd` are held inactive; counters and syncs keep running.
- vbase, input, AW: frame base word address.
- de, output, 1: display enable to the shifter.
- load, output, 1: active-low shifter load strobe.
- mem_rd, output, 1: fetch request to the memory controller for `vid_addr`.
- vid_addr, output, AW: current video word address.
- hsync_n, output, 1: horizontal sync, active low.
- vsync_n, output, 1: vertical sync, active low.

Behaviour:
- State: `ph[1:0]`, `h` (clog2 H_TOTAL), `v` (clog2 V_TOTAL).
  - `ph` increments every clock.
  - An ST boundary is the edge where `ph` goes 3→0.
  - At each ST boundary: `h` increments. At h=H_TOTAL-1 it wraps to 0 and `v` increments; `v` wraps at V_TOTAL-1 to 0.
- All outputs are registered and change only on ST boundaries. Each output holds its value for exactly 4 clocks and reflects the new (h,v) after that edge.
- Reset values:
  - ph=0, h=0, v=0.
  - de=0, load=1, mem_rd=0.
  - hsync_n=0, vsync_n=0 (these are the decode of h=0, v=0).
  - vid_addr=vbase (sampled at reset).
- Assertion of reset mid-frame/mid-load restarts immediately from these values. No partial load strobe survives.
- de = enable && H_DE_START<=h<H_DE_END && V_DE_START<=v<V_DE_END.
- Load slots:
  - Occur on active lines at h = H_DE_START + LOAD_DELAY + 4k, for k = 0 .. N-1, where N = (H_DE_END - H_DE_START)/4. Default N = 80.
  - `load`=0 for that whole ST cycle (4 clocks), 1 otherwise.
  - Slots continue after `de` falls until all N slots are issued.
- mem_rd=1 for the single ST cycle immediately preceding each load slot, with `vid_addr` stable throughout that cycle.
- vid_addr:
  - Increments by 1, modulo 2^AW, at the ST boundary that ends each load slot.
  - Reloads from `vbase` at the ST boundary into h=0, v=0.
  - A `vbase` change mid-frame has no effect until that reload.
- hsync_n = !(h < HSYNC_LEN). vsync_n = !(v < VSYNC_LEN).
- enable:
  - Sampled at every ST boundary.
  - Dropping `enable` mid-line ends any in-progress slot at the next boundary; no further `mem_rd`/`load` is issued.
  - vid_addr does not advance for suppressed slots.
  - Raising `enable` mid-line resumes only from the next line.

Test Plan:
Small config for tests 1–4: H_TOTAL=64, H_DE_START=8, H_DE_END=24, LOAD_DELAY=6, V_TOTAL=8, V_DE_START=2, V_DE_END=4, HSYNC_LEN=4, VSYNC_LEN=1, vbase=0x100.
1. Reset release, enable=1, run to line 2:
   - `de` high for 64 clocks starting 32 clocks into the line.
   - `load` low at clocks 56–59, 72–75, 88–91, 104–107 of the line.
   - `mem_rd` high at clocks 52–55, 68–71, etc.
2. Address check: on line 2, `vid_addr` = 0x100, 0x101, 0x102, 0x103 during the four `mem_rd` cycles. Line 3 starts at 0x104. The next frame restarts at 0x100.
3. Change vbase to 0x200 during line 3 -> line 3 continues from 0x104. After the frame wrap, the first fetch is at 0x200.
4. Drop enable during the 2nd load slot of line 2 -> `load` returns to 1 at the next boundary and no further `mem_rd` on that line. Raise enable -> line 3 issues all 4 slots.
5. Default parameters:
   - 80 load strobes per active line.
   - vid_addr advances by 16000 per frame.
   - hsync_n low for 160 clocks per 2048-clock line.
   - vsync_n low for 3 lines.
6. Assert reset for 1 clock mid-load-slot -> next clock: load=1, de=0, hsync_n=0, vsync_n=0, vid_addr=vbase.
